apb_fsm_controller: RTL and testbench

APB_FSM_CONTROLLER -- requirements
Module: apb_fsm_controller

---
 rtl/ahb2apb_pkg.sv | 38 +++
 rtl/apb_fsm_controller.sv | 137 +++++++++++++
 tb/tb_apb_fsm_controller.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb2apb_pkg.sv
// Shared definitions for the AHB-to-APB bridge controller: FSM state
// encodings, APB select encodings and the bridge address map.
package ahb2apb_pkg;

    // FSM state encodings (3-bit, legacy-compatible constants)
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_READ    = 3'd1;
    localparam logic [2:0] ST_RENABLE = 3'd2;
    localparam logic [2:0] ST_WWAIT   = 3'd3;
    localparam logic [2:0] ST_WRITE   = 3'd4;
    localparam logic [2:0] ST_WENABLE = 3'd5;

    // One-hot APB peripheral selects
    localparam logic [2:0] PSEL_NONE = 3'b000;
    localparam logic [2:0] PSEL_S0   = 3'b001;
    localparam logic [2:0] PSEL_S1   = 3'b010;
    localparam logic [2:0] PSEL_S2   = 3'b100;

    // Bridge address map: three 64 MB peripheral windows, MAP_END is exclusive
    localparam logic [31:0] MAP_S0_BASE = 32'h8000_0000;
    localparam logic [31:0] MAP_S1_BASE = 32'h8400_0000;
    localparam logic [31:0] MAP_S2_BASE = 32'h8800_0000;
    localparam logic [31:0] MAP_END     = 32'h8C00_0000;

    // Reference decode of an address into its one-hot peripheral select
    function automatic logic [2:0] decode_sel(input logic [31:0] addr);
        logic [2:0] sel;
        sel = PSEL_NONE;
        if (addr >= MAP_S0_BASE && addr < MAP_S1_BASE)
            sel = PSEL_S0;
        else if (addr >= MAP_S1_BASE && addr < MAP_S2_BASE)
            sel = PSEL_S1;
        else if (addr >= MAP_S2_BASE && addr < MAP_END)
            sel = PSEL_S2;
        return sel;
    endfunction

endpackage

// File: rtl/apb_fsm_controller.sv
// AHB-to-APB bridge FSM: turns qualified AHB transfers into APB setup and
// access phases, stalling the AHB data phase through Hreadyout.
// Optional feature macro: APB_PREADY_EN adds the Pready input so slaves can
// stretch the access phase; without it every access phase is one cycle.
//
// Handshake: a transfer is taken when valid is high on a rising edge while
// the FSM is in IDLE or in a completing access phase (RENABLE/WENABLE with
// Pready high when present). Hreadyout low tells the master to hold its
// address/data; valid seen in READ, WWAIT or WRITE is ignored.
module apb_fsm_controller
    import ahb2apb_pkg::*;
(
    input  logic        Hclk,
    input  logic        Hresetn,
    input  logic        valid,
    input  logic        Hwrite,
    input  logic [31:0] Haddr,
    input  logic [31:0] Hwdata,
    input  logic [2:0]  tempselx,
`ifdef APB_PREADY_EN
    input  logic        Pready,
`endif
    output logic [31:0] Paddr,
    output logic [31:0] Pwdata,
    output logic        Pwrite,
    output logic [2:0]  Pselx,
    output logic        Penable,
    output logic        Hreadyout,
    output logic [2:0]  o_dbg_state
);

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic        w_hold;
    logic [31:0] r_paddr;
    logic [31:0] r_pwdata;
    logic        r_pwrite;
    logic [2:0]  r_pselx;
    logic [2:0]  r_selx_q;
    logic        r_penable;
    logic        r_hreadyout;

`ifdef APB_PREADY_EN
    logic w_in_access;
    assign w_in_access = (r_state == ST_RENABLE) || (r_state == ST_WENABLE);
    // A slave not ready in the access phase freezes the whole controller
    assign w_hold      = w_in_access && !Pready;
    // Master sees the slave's ready directly while the access phase runs
    assign Hreadyout   = w_in_access ? Pready : r_hreadyout;
`else
    assign w_hold      = 1'b0;
    assign Hreadyout   = r_hreadyout;
`endif

    assign Paddr       = r_paddr;
    assign Pwdata      = r_pwdata;
    assign Pwrite      = r_pwrite;
    assign Pselx       = r_pselx;
    assign Penable     = r_penable;
    assign o_dbg_state = r_state;

    // Next-state decode; IDLE and both enable states share the request exits
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_READ:  w_next_state = ST_RENABLE;
            ST_WWAIT: w_next_state = ST_WRITE;
            ST_WRITE: w_next_state = ST_WENABLE;
            default: begin
                if (!w_hold) begin
                    if (valid && !Hwrite)
                        w_next_state = ST_READ;
                    else if (valid && Hwrite)
                        w_next_state = ST_WWAIT;
                    else
                        w_next_state = ST_IDLE;
                end
            end
        endcase
    end

    // State register
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn)
            r_state <= ST_IDLE;
        else
            r_state <= w_next_state;
    end

    // Output registers, loaded according to the state being entered
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_pwrite    <= 1'b0;
            r_pselx     <= PSEL_NONE;
            r_selx_q    <= PSEL_NONE;
            r_penable   <= 1'b0;
            r_hreadyout <= 1'b1;
        end else if (!w_hold) begin
            case (w_next_state)
                ST_READ: begin
                    r_paddr     <= Haddr;
                    r_pselx     <= tempselx;
                    r_pwrite    <= 1'b0;
                    r_penable   <= 1'b0;
                    r_hreadyout <= 1'b0;
                end
                ST_WWAIT: begin
                    // Select is parked until write data arrives next cycle
                    r_paddr     <= Haddr;
                    r_selx_q    <= tempselx;
                    r_pwrite    <= 1'b1;
                    r_pselx     <= PSEL_NONE;
                    r_penable   <= 1'b0;
                    r_hreadyout <= 1'b0;
                end
                ST_WRITE: begin
                    r_pwdata    <= Hwdata;
                    r_pselx     <= r_selx_q;
                    r_penable   <= 1'b0;
                    r_hreadyout <= 1'b0;
                end
                ST_RENABLE, ST_WENABLE: begin
                    r_penable   <= 1'b1;
                    r_hreadyout <= 1'b1;
                end
                default: begin
                    r_pselx     <= PSEL_NONE;
                    r_penable   <= 1'b0;
                    r_hreadyout <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Bench for apb_fsm_controller: directed vector table, multi-cycle corner
// sequences and randomized traffic against a transaction-phase model.
module tb_apb_fsm_controller;
    import ahb2apb_pkg::*;

`ifdef APB_PREADY_EN
    localparam bit HAS_PREADY = 1'b1;
`else
    localparam bit HAS_PREADY = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic        Hclk     = 1'b0;
    logic        Hresetn  = 1'b1;
    logic        valid    = 1'b0;
    logic        Hwrite   = 1'b0;
    logic [31:0] Haddr    = '0;
    logic [31:0] Hwdata   = '0;
    logic [2:0]  tempselx = '0;
    logic        Pready   = 1'b1;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic        Pwrite;
    logic [2:0]  Pselx;
    logic        Penable;
    logic        Hreadyout;
    logic [2:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Hclk = ~Hclk;

    apb_fsm_controller dut (
        .Hclk        (Hclk),
        .Hresetn     (Hresetn),
        .valid       (valid),
        .Hwrite      (Hwrite),
        .Haddr       (Haddr),
        .Hwdata      (Hwdata),
        .tempselx    (tempselx),
`ifdef APB_PREADY_EN
        .Pready      (Pready),
`endif
        .Paddr       (Paddr),
        .Pwdata      (Pwdata),
        .Pwrite      (Pwrite),
        .Pselx       (Pselx),
        .Penable     (Penable),
        .Hreadyout   (Hreadyout),
        .o_dbg_state (dbg_state)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no summary, want completion");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_paddr, input logic [31:0] e_pwdata,
                             input logic e_pwrite, input logic [2:0] e_pselx, input logic e_pen,
                             input logic e_hr);
        check({tag, ".paddr"},     Paddr,          e_paddr);
        check({tag, ".pwdata"},    Pwdata,         e_pwdata);
        check({tag, ".pwrite"},    32'(Pwrite),    32'(e_pwrite));
        check({tag, ".pselx"},     32'(Pselx),     32'(e_pselx));
        check({tag, ".penable"},   32'(Penable),   32'(e_pen));
        check({tag, ".hreadyout"}, 32'(Hreadyout), 32'(e_hr));
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic v, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] s);
        valid = v; Hwrite = w; Haddr = a; Hwdata = d; tempselx = s;
    endtask

    // advance one edge and settle just after it
    task automatic step();
        @(posedge Hclk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        v;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  s;
        logic [31:0] e_paddr;
        logic [31:0] e_pwdata;
        logic        e_pwrite;
        logic [2:0]  e_pselx;
        logic        e_pen;
        logic        e_hr;
        logic [2:0]  e_state;
    } vec_t;

    vec_t vecs[12];

    // ---------------- reference model ----------------
    // A transfer is a list of phases: read = setup, access;
    // write = wait (no select), setup, access. Idle otherwise.
    bit          m_busy;
    bit          m_wr;
    int          m_phase;
    logic [31:0] m_addr;
    logic [31:0] m_data;
    logic [2:0]  m_sel;
    logic        m_pwrite;

    function automatic int m_last();
        return m_wr ? 2 : 1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_wr = 0; m_phase = 0;
        m_addr = '0; m_data = '0; m_sel = '0; m_pwrite = 1'b0;
    endtask

    task automatic model_check(input int cyc);
        logic [2:0] e_sel;
        logic       e_pen;
        logic       e_hr;
        string      tag;
        if (!m_busy) begin
            e_sel = 3'b000; e_pen = 1'b0; e_hr = 1'b1;
        end else if (m_phase < m_last()) begin
            e_sel = (m_wr && m_phase == 0) ? 3'b000 : m_sel;
            e_pen = 1'b0; e_hr = 1'b0;
        end else begin
            e_sel = m_sel; e_pen = 1'b1;
            e_hr  = Pready | ~HAS_PREADY;
        end
        tag = $sformatf("rand%0d", cyc);
        check_all(tag, m_addr, m_data, m_pwrite, e_sel, e_pen, e_hr);
    endtask

    task automatic model_step();
        bit ready_ok;
        ready_ok = Pready | ~HAS_PREADY;
        if (m_busy && m_phase < m_last()) begin
            if (m_wr && m_phase == 0)
                m_data = Hwdata;
            m_phase++;
        end else if (m_busy && !ready_ok) begin
            // access phase stretched by the slave
        end else if (valid) begin
            m_busy = 1; m_wr = Hwrite; m_phase = 0;
            m_addr = Haddr; m_sel = tempselx; m_pwrite = Hwrite;
        end else begin
            m_busy = 0;
        end
    endtask

    // ---------------- test ----------------
    initial begin
        int r;

        vecs[0]  = '{1'b1, 1'b0, 32'h8000_0010, 32'h0, 3'b001,
                     32'h8000_0010, 32'h0, 1'b0, 3'b001, 1'b0, 1'b0, ST_READ};
        vecs[1]  = '{1'b1, 1'b1, 32'h8400_0020, 32'h0, 3'b010,
                     32'h8000_0010, 32'h0, 1'b0, 3'b001, 1'b1, 1'b1, ST_RENABLE};
        vecs[2]  = '{1'b0, 1'b0, 32'h0, 32'h0, 3'b000,
                     32'h8000_0010, 32'h0, 1'b0, 3'b000, 1'b0, 1'b1, ST_IDLE};
        vecs[3]  = '{1'b1, 1'b1, 32'h8400_0020, 32'h0, 3'b010,
                     32'h8400_0020, 32'h0, 1'b1, 3'b000, 1'b0, 1'b0, ST_WWAIT};
        vecs[4]  = '{1'b0, 1'b0, 32'h8400_0020, 32'hDEAD_BEEF, 3'b010,
                     32'h8400_0020, 32'hDEAD_BEEF, 1'b1, 3'b010, 1'b0, 1'b0, ST_WRITE};
        vecs[5]  = '{1'b0, 1'b0, 32'h8400_0020, 32'hDEAD_BEEF, 3'b010,
                     32'h8400_0020, 32'hDEAD_BEEF, 1'b1, 3'b010, 1'b1, 1'b1, ST_WENABLE};
        vecs[6]  = '{1'b1, 1'b0, 32'h8800_0000, 32'h0, 3'b100,
                     32'h8800_0000, 32'hDEAD_BEEF, 1'b0, 3'b100, 1'b0, 1'b0, ST_READ};
        vecs[7]  = '{1'b1, 1'b1, 32'h8000_0040, 32'h0, 3'b001,
                     32'h8800_0000, 32'hDEAD_BEEF, 1'b0, 3'b100, 1'b1, 1'b1, ST_RENABLE};
        vecs[8]  = '{1'b1, 1'b1, 32'h8000_0040, 32'h0, 3'b001,
                     32'h8000_0040, 32'hDEAD_BEEF, 1'b1, 3'b000, 1'b0, 1'b0, ST_WWAIT};
        vecs[9]  = '{1'b0, 1'b1, 32'h8000_0040, 32'h1234_5678, 3'b001,
                     32'h8000_0040, 32'h1234_5678, 1'b1, 3'b001, 1'b0, 1'b0, ST_WRITE};
        vecs[10] = '{1'b0, 1'b0, 32'h0, 32'h1234_5678, 3'b000,
                     32'h8000_0040, 32'h1234_5678, 1'b1, 3'b001, 1'b1, 1'b1, ST_WENABLE};
        vecs[11] = '{1'b0, 1'b0, 32'h0, 32'h0, 3'b000,
                     32'h8000_0040, 32'h1234_5678, 1'b1, 3'b000, 1'b0, 1'b1, ST_IDLE};

        // reset values, checked while reset is held
        #2 Hresetn = 1'b0;
        #1;
        check_all("reset", 32'h0, 32'h0, 1'b0, 3'b000, 1'b0, 1'b1);
        check("reset.state", 32'(dbg_state), 32'(ST_IDLE));
        @(negedge Hclk);
        @(negedge Hclk) Hresetn = 1'b1;
        step();

        // directed table: single read, ignored request, single write, back-to-back
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].v, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].s);
            step();
            check_all($sformatf("vec%0d", i), vecs[i].e_paddr, vecs[i].e_pwdata, vecs[i].e_pwrite,
                      vecs[i].e_pselx, vecs[i].e_pen, vecs[i].e_hr);
            check($sformatf("vec%0d.state", i), 32'(dbg_state), 32'(vecs[i].e_state));
        end

        // reset asserted in the middle of a WRITE aborts it without a clock edge
        drive(1'b1, 1'b1, 32'h8800_0100, 32'h0, 3'b100);
        step();
        drive(1'b0, 1'b0, 32'h8800_0100, 32'hA5A5_5A5A, 3'b100);
        step();
        check("midwr.pre_state", 32'(dbg_state), 32'(ST_WRITE));
        #2 Hresetn = 1'b0;
        #1;
        check_all("midwr_rst", 32'h0, 32'h0, 1'b0, 3'b000, 1'b0, 1'b1);
        @(negedge Hclk) Hresetn = 1'b1;
        // first post-reset edge evaluates the idle exits
        drive(1'b1, 1'b0, 32'h8000_0100, 32'h0, 3'b001);
        step();
        check_all("post_rst", 32'h8000_0100, 32'h0, 1'b0, 3'b001, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        step();
        step();
        check("post_rst.idle", 32'(dbg_state), 32'(ST_IDLE));

`ifdef APB_PREADY_EN
        // slave stalls the write access phase for two cycles
        drive(1'b1, 1'b1, 32'h8400_0200, 32'h0, 3'b010);
        step();
        drive(1'b0, 1'b0, 32'h8400_0200, 32'h0BAD_F00D, 3'b010);
        step();
        step();
        check("prdy.enter", 32'(dbg_state), 32'(ST_WENABLE));
        Pready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            check_all($sformatf("prdy_wait%0d", k), 32'h8400_0200, 32'h0BAD_F00D, 1'b1, 3'b010, 1'b1, 1'b0);
            step();
            check($sformatf("prdy_wait%0d.state", k), 32'(dbg_state), 32'(ST_WENABLE));
        end
        Pready = 1'b1;
        #1;
        check("prdy.release_hr", 32'(Hreadyout), 32'h1);
        step();
        check_all("prdy_done", 32'h8400_0200, 32'h0BAD_F00D, 1'b1, 3'b000, 1'b0, 1'b1);
`endif

        // randomized traffic against the phase model
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        Pready = 1'b1;
        #2 Hresetn = 1'b0;
        model_reset();
        @(negedge Hclk) Hresetn = 1'b1;
        step();
        for (int c = 0; c < 600; c++) begin
            r = $urandom_range(0, 2);
            valid    = 1'($urandom_range(0, 1));
            Hwrite   = 1'($urandom_range(0, 1));
            Haddr    = MAP_S0_BASE + 32'(r) * 32'h0400_0000 + ($urandom & 32'h03FF_FFFC);
            tempselx = decode_sel(Haddr);
            Hwdata   = $urandom;
            Pready   = ($urandom_range(0, 3) != 0);
            #1;
            model_check(c);
            @(posedge Hclk);
            model_step();
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
